llc_flush_sweeper: RTL
======================

Name: llc_flush_sweeper

Overview:
- Sequencer that drives the LLC local-memory array port from the requester side.
- Runs two sweep modes, one set at a time:
  - reset-init: clears state and dirty bits for every way and zeroes the evict-way pointer.
  - flush: reads each set, writes back dirty valid lines over a valid/ready channel, then invalidates every valid way.
- Sits beside the LLC controller and owns the array port while busy.

Parameters:
NUM_SETS, 512, sets in array (power of two)
SET_BITS, 9, log2(NUM_SETS)
NUM_WAYS, 16, ways per set
WAY_BITS, 4, log2(NUM_WAYS)
TAG_BITS, 15, tag width
LINE_BITS, 128, line width
STATE_BITS, 3, LLC state width; INVALID encodes as 0

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin sweep; sampled only in IDLE
mode  in  1  0 = reset-init, 1 = flush; sampled with start
busy  out  1  high from the cycle after start is accepted through the DONE cycle
done  out  1  one-cycle pulse at sweep end
rd_en  out  1  array read strobe
set_out  out  SET_BITS  array set index
wr_rst_flush  out  NUM_WAYS  per-way state/dirty clear strobe
wr_data_state  out  STATE_BITS  state write data; constant 0
wr_data_dirty_bit  out  1  dirty write data; constant 0
wr_en_evict_way  out  1  evict-way pointer write strobe
wr_data_evict_way  out  WAY_BITS  evict-way write data; constant 0
rd_data_state  in  NUM_WAYS*STATE_BITS  per-way state, way w at [w*STATE_BITS +: STATE_BITS]
rd_data_dirty_bit  in  NUM_WAYS  per-way dirty bit
rd_data_tag  in  NUM_WAYS*TAG_BITS  per-way tag
rd_data_line  in  NUM_WAYS*LINE_BITS  per-way line data
wb_valid  out  1  writeback request valid
wb_ready  in  1  writeback sink ready
wb_addr  out  TAG_BITS+SET_BITS  line address {tag, set}
wb_line  out  LINE_BITS  line data

Behaviour:
- One clock (clk). Reset rst is synchronous, active-high.
- Reset state: FSM in IDLE, set counter 0. All outputs 0: busy, done, rd_en, set_out, wr_rst_flush, wr_en_evict_way, wb_valid, wb_addr, wb_line.
- Reset asserted mid-sweep:
  - Next edge returns the FSM to IDLE.
  - wb_valid drops even without a handshake; the pending writeback is abandoned.
  - No done pulse.
- FSM states: IDLE, RST_SET, RD_REQ, RD_WAIT, SCAN, WB, INVAL, DONE.
- IDLE:
  - start=1 clears the set counter.
  - Next state is RST_SET if mode=0, RD_REQ if mode=1.
- RST_SET (one cycle per set):
  - wr_rst_flush all ones; wr_en_evict_way=1; set_out = counter.
  - If counter==NUM_SETS-1, go to DONE; else increment and stay.
  - Total NUM_SETS cycles; no reads.
- RD_REQ: rd_en=1, set_out = counter. Next state RD_WAIT.
- RD_WAIT:
  - Array data is valid this cycle (1-cycle SRAM latency).
  - Latch snapshot registers: valid[w] = (state[w]!=0), pend[w] = valid[w] & dirty[w], tags, lines.
  - Next state SCAN.
- SCAN:
  - If pend != 0, select the lowest-index set bit as the current way and go to WB.
  - Else go to INVAL.
  - Zero rd_en in SCAN, WB and INVAL.
- WB:
  - wb_valid=1; wb_addr = {tag[cur], counter}; wb_line = line[cur].
  - All wb outputs held stable until wb_ready.
  - On wb_valid & wb_ready: clear pend[cur], go to SCAN.
- INVAL:
  - One cycle; wr_rst_flush = valid snapshot; set_out = counter.
  - No write strobe if the set has no valid ways (mask 0).
  - If counter==NUM_SETS-1, go to DONE; else increment and go to RD_REQ.
- DONE: done=1 for one cycle, busy still 1. Next state IDLE.
- Start is ignored in every state except IDLE.
- set_out holds the counter in every non-IDLE state and is 0 in IDLE.
- Flush of a set with k dirty lines and zero sink stall takes 4 + 2k cycles.

Test Plan:
- Reset-init, NUM_SETS=8, NUM_WAYS=4: start, mode=0
  -> wr_rst_flush=4'hF and wr_en_evict_way=1 for 8 consecutive cycles, set_out 0..7;
  -> done exactly one cycle after set 7; rd_en never asserts.
- Flush, all sets invalid
  -> per set: one rd_en, then INVAL with wr_rst_flush=0;
  -> no wb_valid; done after 8*4 cycles.
- Flush, set 3 has ways 1 and 2 valid and dirty (tags 0x11, 0x22), way 0 valid and clean, wb_ready tied 1
  -> wb_addr={0x11,3} then {0x22,3} on consecutive handshakes;
  -> wr_rst_flush=4'b0111 at set 3.
- Backpressure: wb_ready low for 5 cycles during WB
  -> wb_valid, wb_addr and wb_line stable throughout; single handshake when ready rises.
- start pulsed while busy, and start together with mode toggling mid-sweep
  -> ignored; exactly one done pulse.
- rst asserted while wb_valid=1
  -> next cycle all outputs 0 and FSM in IDLE;
  -> a new flush start afterwards begins again at set 0.

Source files
------------

// File: rtl/llc_flush_sweeper.sv
// LLC array sweeper: reset-init clears every set, flush writes back dirty lines then invalidates.
// States: IDLE, RST_SET (clear one set), RD_REQ/RD_WAIT (read set), SCAN/WB (drain dirty ways), INVAL, DONE.
module llc_flush_sweeper #(
  parameter int NUM_SETS   = 512,
  parameter int SET_BITS   = 9,
  parameter int NUM_WAYS   = 16,
  parameter int WAY_BITS   = 4,
  parameter int TAG_BITS   = 15,
  parameter int LINE_BITS  = 128,
  parameter int STATE_BITS = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            mode,
  output logic                            busy,
  output logic                            done,
  output logic                            rd_en,
  output logic [SET_BITS-1:0]             set_out,
  output logic [NUM_WAYS-1:0]             wr_rst_flush,
  output logic [STATE_BITS-1:0]           wr_data_state,
  output logic                            wr_data_dirty_bit,
  output logic                            wr_en_evict_way,
  output logic [WAY_BITS-1:0]             wr_data_evict_way,
  input  logic [NUM_WAYS*STATE_BITS-1:0]  rd_data_state,
  input  logic [NUM_WAYS-1:0]             rd_data_dirty_bit,
  input  logic [NUM_WAYS*TAG_BITS-1:0]    rd_data_tag,
  input  logic [NUM_WAYS*LINE_BITS-1:0]   rd_data_line,
  output logic                            wb_valid,
  input  logic                            wb_ready,
  output logic [TAG_BITS+SET_BITS-1:0]    wb_addr,
  output logic [LINE_BITS-1:0]            wb_line
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST_SET, S_RD_REQ, S_RD_WAIT, S_SCAN, S_WB, S_INVAL, S_DONE
  } state_e;

  state_e                        state_q, state_d;
  logic [SET_BITS-1:0]           set_q, set_d;
  logic [NUM_WAYS-1:0]           valid_q, valid_d;
  logic [NUM_WAYS-1:0]           pend_q, pend_d;
  logic [WAY_BITS-1:0]           cur_q, cur_d;
  logic [NUM_WAYS*TAG_BITS-1:0]  tag_q;
  logic [NUM_WAYS*LINE_BITS-1:0] line_q;
  logic [WAY_BITS-1:0]           first_way;
  logic                          last_set;

  assign last_set          = (set_q == SET_BITS'(NUM_SETS - 1));
  assign wr_data_state     = '0;
  assign wr_data_dirty_bit = 1'b0;
  assign wr_data_evict_way = '0;

  // Lowest-index pending way wins.
  always_comb begin
    first_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (pend_q[w]) first_way = WAY_BITS'(w);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      set_q   <= '0;
      valid_q <= '0;
      pend_q  <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      cur_q   <= cur_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_RD_WAIT) begin
      tag_q  <= rd_data_tag;
      line_q <= rd_data_line;
    end
  end

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    cur_d   = cur_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          set_d   = '0;
          state_d = mode ? S_RD_REQ : S_RST_SET;
        end
      end
      S_RST_SET: begin
        if (last_set) state_d = S_DONE;
        else          set_d   = set_q + 1'b1;
      end
      S_RD_REQ: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_d[w] = |rd_data_state[w*STATE_BITS +: STATE_BITS];
          pend_d[w]  = valid_d[w] & rd_data_dirty_bit[w];
        end
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (|pend_q) begin
          cur_d   = first_way;
          state_d = S_WB;
        end else begin
          state_d = S_INVAL;
        end
      end
      S_WB: begin
        if (wb_ready) begin
          pend_d[cur_q] = 1'b0;
          state_d       = S_SCAN;
        end
      end
      S_INVAL: begin
        if (last_set) begin
          state_d = S_DONE;
        end else begin
          set_d   = set_q + 1'b1;
          state_d = S_RD_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy            = (state_q != S_IDLE);
    done            = (state_q == S_DONE);
    rd_en           = (state_q == S_RD_REQ);
    set_out         = (state_q != S_IDLE) ? set_q : '0;
    wr_rst_flush    = '0;
    wr_en_evict_way = 1'b0;
    wb_valid        = 1'b0;
    wb_addr         = '0;
    wb_line         = '0;
    unique case (state_q)
      S_RST_SET: begin
        wr_rst_flush    = '1;
        wr_en_evict_way = 1'b1;
      end
      S_INVAL: wr_rst_flush = valid_q;
      S_WB: begin
        wb_valid = 1'b1;
        wb_addr  = {tag_q[int'(cur_q)*TAG_BITS +: TAG_BITS], set_q};
        wb_line  = line_q[int'(cur_q)*LINE_BITS +: LINE_BITS];
      end
      default: ;
    endcase
  end

endmodule
